split_mul_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational 8-bit / dual-4-bit multiplier. It adds a valid/ready handshake, a three-stage pipeline and per-group accumulation. It sits between the PE operand fetch and the psum write-back. It emits one PSUM_WIDTH result per dot-product group, as either a full-width sum or two independent half-width lane sums.

---
 rtl/split_mul_pipe.sv | 165 ++++++++++++++++
 tb/tb_split_mul_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/split_mul_pipe.sv
// Three-stage pipelined signed/unsigned multiply-accumulate with a full-width
// or dual half-width lane mode, valid/ready handshake and per-group output.
module split_mul_pipe #(
  parameter int A_W        = 8,
  parameter int B_W        = 8,
  parameter int PSUM_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic                  is_first,
  input  logic [A_W-1:0]        a,
  input  logic [B_W-1:0]        b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_data
);
  localparam int HA = A_W / 2;
  localparam int HP = PSUM_WIDTH / 2;
  localparam int FW = A_W + B_W;
  localparam int LW = HA + B_W;

  logic                  w_adv, w_accept, w_mode_eff, w_first_eff;
  logic                  w_an, w_hn, w_ln, w_bn;
  logic [A_W-1:0]        w_am;
  logic [HA-1:0]         w_hm, w_lm;
  logic [B_W-1:0]        w_bm;
  logic [PSUM_WIDTH-1:0] w_pf_x, w_pf_s, w_sum;
  logic [HP-1:0]         w_ph_x, w_ph_s, w_pl_x, w_pl_s;

  logic                  r_grp_open, r_mode_l, r_first_l;
  logic                  r1_valid, r1_last, r1_mode, r1_an, r1_hn, r1_ln, r1_bn;
  logic [A_W-1:0]        r1_am;
  logic [HA-1:0]         r1_hm, r1_lm;
  logic [B_W-1:0]        r1_bm;
  logic                  r2_valid, r2_last, r2_mode, r2_fn, r2_hn, r2_ln;
  logic [FW-1:0]         r2_pf;
  logic [LW-1:0]         r2_ph, r2_pl;
  logic [PSUM_WIDTH-1:0] r_acc, r_out_data;
  logic                  r_out_valid;

  assign w_adv     = !(r_out_valid && !out_ready);
  assign in_ready  = w_adv && rst_n;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // mode/is_first come live on a group's first beat and from the latch afterwards
  always_comb begin
    w_mode_eff  = mode;
    w_first_eff = is_first;
    if (r_grp_open) begin
      w_mode_eff  = r_mode_l;
      w_first_eff = r_first_l;
    end else begin
      w_mode_eff  = mode;
      w_first_eff = is_first;
    end
  end

  // Operand conversion to sign-magnitude; magnitudes fit because the most negative value maps to 2^(n-1)
  always_comb begin
    w_an = !w_first_eff && a[A_W-1];
    w_hn = !w_first_eff && a[A_W-1];
    w_ln = !w_first_eff && a[HA-1];
    w_bn = b[B_W-1];
    w_am = w_an ? -a : a;
    w_hm = w_hn ? -a[A_W-1:HA] : a[A_W-1:HA];
    w_lm = w_ln ? -a[HA-1:0] : a[HA-1:0];
    w_bm = w_bn ? -b : b;
  end

  // Group tracking and latch of the group's mode/signedness
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grp_open <= 1'b0;
      r_mode_l   <= 1'b0;
      r_first_l  <= 1'b0;
    end else if (w_accept) begin
      r_grp_open <= !in_last;
      if (!r_grp_open) begin
        r_mode_l  <= mode;
        r_first_l <= is_first;
      end
    end
  end

  // S1: sign-magnitude operand register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid <= 1'b0; r1_last <= 1'b0; r1_mode <= 1'b0;
      r1_an    <= 1'b0; r1_hn   <= 1'b0; r1_ln   <= 1'b0; r1_bn <= 1'b0;
      r1_am    <= {A_W{1'b0}};
      r1_hm    <= {HA{1'b0}};
      r1_lm    <= {HA{1'b0}};
      r1_bm    <= {B_W{1'b0}};
    end else if (w_adv) begin
      r1_valid <= w_accept;
      r1_last  <= in_last;
      r1_mode  <= w_mode_eff;
      r1_an <= w_an; r1_hn <= w_hn; r1_ln <= w_ln; r1_bn <= w_bn;
      r1_am <= w_am; r1_hm <= w_hm; r1_lm <= w_lm; r1_bm <= w_bm;
    end
  end

  // S2: unsigned magnitude products and their result signs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_valid <= 1'b0; r2_last <= 1'b0; r2_mode <= 1'b0;
      r2_fn    <= 1'b0; r2_hn   <= 1'b0; r2_ln   <= 1'b0;
      r2_pf    <= {FW{1'b0}};
      r2_ph    <= {LW{1'b0}};
      r2_pl    <= {LW{1'b0}};
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_last  <= r1_last;
      r2_mode  <= r1_mode;
      r2_fn    <= r1_an ^ r1_bn;
      r2_hn    <= r1_hn ^ r1_bn;
      r2_ln    <= r1_ln ^ r1_bn;
      r2_pf    <= FW'(r1_am) * FW'(r1_bm);
      r2_ph    <= LW'(r1_hm) * LW'(r1_bm);
      r2_pl    <= LW'(r1_lm) * LW'(r1_bm);
    end
  end

  // S3 datapath: signed products and wrap-around sums; lanes are added separately so no carry crosses
  always_comb begin
    w_pf_x = PSUM_WIDTH'(r2_pf);
    w_ph_x = HP'(r2_ph);
    w_pl_x = HP'(r2_pl);
    w_pf_s = r2_fn ? -w_pf_x : w_pf_x;
    w_ph_s = r2_hn ? -w_ph_x : w_ph_x;
    w_pl_s = r2_ln ? -w_pl_x : w_pl_x;
    w_sum  = r_acc + w_pf_s;
    if (r2_mode) begin
      w_sum = {r_acc[PSUM_WIDTH-1:HP] + w_ph_s, r_acc[HP-1:0] + w_pl_s};
    end else begin
      w_sum = r_acc + w_pf_s;
    end
  end

  // S3: accumulator and output register; a last beat publishes and restarts the group
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= {PSUM_WIDTH{1'b0}};
      r_out_data  <= {PSUM_WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      if (r2_valid && r2_last) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
        r_acc       <= {PSUM_WIDTH{1'b0}};
      end else begin
        r_out_valid <= 1'b0;
        if (r2_valid) begin
          r_acc <= w_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_split_mul_pipe.sv
// Self-checking bench for split_mul_pipe: vector table through a scoreboard
// plus hand-written latency, throughput, backpressure and reset sequences.
module tb_split_mul_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, mode, is_first, in_last, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [23:0] out_data;

  always #5 clk = ~clk;

  split_mul_pipe #(.A_W(8), .B_W(8), .PSUM_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .is_first(is_first), .a(a), .b(b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  typedef struct {
    logic        m;
    logic        f;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        l;
    logic [23:0] e;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  function automatic void chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endfunction

  task automatic add_vec(input logic m, input logic f, input logic [7:0] av, input logic [7:0] bv,
                         input logic l, input logic [23:0] e);
    vec_t v;
    v.m = m; v.f = f; v.a = av; v.b = bv; v.l = l; v.e = e;
    tbl.push_back(v);
  endtask

  // Called at a negedge with inputs set; samples both handshakes, then moves to the next negedge.
  task automatic tick(output logic acc);
    logic [23:0] e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %h want no output", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_out", out_data, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input logic m, input logic f, input logic [7:0] av, input logic [7:0] bv,
                           input logic l, input logic [23:0] e);
    logic acc;
    int   n;
    mode = m; is_first = f; a = av; b = bv; in_last = l; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL accept_timeout: got no accept want accept");
    end else if (l) begin
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic d;
    int   n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      tick(d);
      n++;
    end
    chk("drain_empty", 24'(exp_q.size()), 24'd0);
    repeat (3) tick(d);
  endtask

  initial begin
    logic d;
    int   cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 1'b0; is_first = 1'b0; in_last = 1'b0; a = 8'h00; b = 8'h00;

    add_vec(1'b0, 1'b0, 8'hF6, 8'h07, 1'b1, 24'hFFFFBA);
    add_vec(1'b0, 1'b1, 8'hF6, 8'hFE, 1'b1, 24'hFFFE14);
    add_vec(1'b1, 1'b0, 8'h7F, 8'h10, 1'b1, 24'h070FF0);
    add_vec(1'b1, 1'b1, 8'h7F, 8'h10, 1'b1, 24'h0700F0);
    add_vec(1'b0, 1'b0, 8'h02, 8'h03, 1'b0, 24'h000000);
    add_vec(1'b0, 1'b0, 8'hFF, 8'h05, 1'b0, 24'h000000);
    add_vec(1'b0, 1'b0, 8'h04, 8'h04, 1'b1, 24'h000011);
    add_vec(1'b1, 1'b1, 8'h1F, 8'h7F, 1'b0, 24'h000000);
    add_vec(1'b1, 1'b1, 8'h0B, 8'h0D, 1'b1, 24'h07F800);
    add_vec(1'b1, 1'b1, 8'h0F, 8'h7F, 1'b0, 24'h000000);
    add_vec(1'b1, 1'b1, 8'h0F, 8'h7F, 1'b0, 24'h000000);
    add_vec(1'b1, 1'b1, 8'h0F, 8'h7F, 1'b1, 24'h000653);
    add_vec(1'b1, 1'b1, 8'h11, 8'h02, 1'b0, 24'h000000);
    add_vec(1'b0, 1'b0, 8'hFF, 8'h01, 1'b1, 24'h011011);
    add_vec(1'b0, 1'b0, 8'h80, 8'h80, 1'b1, 24'h004000);
    add_vec(1'b0, 1'b1, 8'hFF, 8'h80, 1'b1, 24'hFF8080);
    add_vec(1'b1, 1'b0, 8'h88, 8'h80, 1'b1, 24'h400400);
    add_vec(1'b1, 1'b1, 8'hFF, 8'h7F, 1'b1, 24'h771771);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 24'(in_ready), 24'd0);
    chk("rst_out_valid", 24'(out_valid), 24'd0);
    chk("rst_out_data", out_data, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) send_beat(tbl[i].m, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].l, tbl[i].e);
    drain();

    // Latency: last beat accepted at cycle t shows out_valid at t+3
    send_beat(1'b0, 1'b0, 8'h06, 8'h07, 1'b1, 24'h00002A);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick(d);
      cnt++;
    end
    chk("latency", 24'(cnt), 24'd2);
    drain();

    // Throughput: back-to-back single-beat groups give consecutive out_valid
    send_beat(1'b0, 1'b0, 8'h01, 8'h02, 1'b1, 24'h000002);
    send_beat(1'b0, 1'b0, 8'h03, 8'h02, 1'b1, 24'h000006);
    tick(d);
    chk("tput_first", 24'(out_valid), 24'd1);
    tick(d);
    chk("tput_second", 24'(out_valid), 24'd1);
    drain();

    // Backpressure: hold result, refuse beats, then deliver all in order
    out_ready = 1'b0;
    send_beat(1'b0, 1'b0, 8'h03, 8'h03, 1'b1, 24'h000009);
    send_beat(1'b0, 1'b0, 8'hFE, 8'h03, 1'b1, 24'hFFFFFA);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick(d);
      cnt++;
    end
    mode = 1'b1; is_first = 1'b0; a = 8'h21; b = 8'hF0; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_data", out_data, 24'h000009);
      chk("stall_valid", 24'(out_valid), 24'd1);
      chk("stall_in_ready", 24'(in_ready), 24'd0);
      tick(d);
      chk("stall_no_accept", 24'(d), 24'd0);
    end
    out_ready = 1'b1;
    send_beat(1'b1, 1'b0, 8'h21, 8'hF0, 1'b1, 24'hFE0FF0);
    drain();

    // Reset mid-group discards the partial sum
    send_beat(1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 24'h000000);
    send_beat(1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 24'h000000);
    rst_n = 1'b0;
    tick(d);
    chk("rst_mid_in_ready", 24'(in_ready), 24'd0);
    rst_n = 1'b1;
    send_beat(1'b0, 1'b0, 8'h01, 8'h01, 1'b1, 24'h000001);
    drain();

    // Reset mid-stall drops the held result
    out_ready = 1'b0;
    send_beat(1'b0, 1'b0, 8'h02, 8'h02, 1'b1, 24'h000004);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick(d);
      cnt++;
    end
    chk("stall_before_rst", 24'(out_valid), 24'd1);
    rst_n = 1'b0;
    tick(d);
    chk("rst_stall_valid", 24'(out_valid), 24'd0);
    chk("rst_stall_data", out_data, 24'd0);
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_beat(1'b0, 1'b1, 8'h03, 8'h04, 1'b1, 24'h00000C);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
